cycpuf_crp_driver: RTL and testbench

Challenge-side driver for the cyclic-BPUF array. It accepts a seed and a word count, generates a pseudo-random challenge sequence with an LFSR, and applies each challenge to the PUF's `Chal` input. For each challenge it waits a settle window and majority-votes the 1-bit PUF response. It packs the voted bits into words and streams them out over a valid/ready handshake. It sits between the enrollment/authentication controller and the PUF top.

---
 rtl/cycpuf_pkg.sv | 24 ++
 rtl/cycpuf_crp_driver_if.sv | 33 +++
 rtl/cycpuf_lfsr.sv | 43 ++++
 rtl/cycpuf_crp_driver.sv | 156 +++++++++++++++
 tb/tb_cycpuf_crp_driver.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cycpuf_pkg.sv
// Shared definitions for the cyclic-BPUF challenge driver.
//   - cyc_state_e    : driver FSM states
//   - CYC_CHAL_W     : default challenge width (matches the PUF Chal bus)
//   - CYC_TAPS       : default Fibonacci feedback mask (taps 50,5,2,0)
//   - maj_threshold(): vote count that must be exceeded for a '1'
package cycpuf_pkg;

    localparam int unsigned CYC_CHAL_W = 51;
    localparam logic [CYC_CHAL_W-1:0] CYC_TAPS = 51'h4000000000025;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StSample,
        StEmit
    } cyc_state_e;

    // A voted bit is 1 when the number of ones is strictly greater than this.
    function automatic int unsigned maj_threshold(input int unsigned votes);
        return votes / 2;
    endfunction

endpackage

// File: rtl/cycpuf_crp_driver_if.sv
// Request/response bus between the enrollment/authentication controller and
// the challenge driver.
//   Request : seed_valid, seed_ready, seed[CHAL_W], num_words[16]
//   Response: out_valid, out_ready, out_data[RESP_W], out_last
// Modports: master = controller side, slave = driver side.
interface cycpuf_crp_driver_if
    import cycpuf_pkg::*;
#(
    parameter int unsigned CHAL_W = CYC_CHAL_W,
    parameter int unsigned RESP_W = 32
) ();

    logic              seed_valid;
    logic              seed_ready;
    logic [CHAL_W-1:0] seed;
    logic [15:0]       num_words;

    logic              out_valid;
    logic              out_ready;
    logic [RESP_W-1:0] out_data;
    logic              out_last;

    modport master (
        output seed_valid, seed, num_words, out_ready,
        input  seed_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  seed_valid, seed, num_words, out_ready,
        output seed_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/cycpuf_lfsr.sv
// CHAL_W-bit Fibonacci LFSR used as the challenge generator.
//   clk, rst_n : clock, synchronous active-low reset
//   load, seed : load seed (an all-zero seed becomes 1, the lock-up state)
//   step       : shift left, feedback = XOR of state bits selected by TAPS
//   state      : current LFSR contents
// load takes priority over step.
module cycpuf_lfsr
    import cycpuf_pkg::*;
#(
    parameter int unsigned       CHAL_W = CYC_CHAL_W,
    parameter logic [CHAL_W-1:0] TAPS   = CYC_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CHAL_W-1:0] seed,
    input  logic              step,
    output logic [CHAL_W-1:0] state
);

    logic [CHAL_W-1:0] state_q;
    logic [CHAL_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == '0) ? CHAL_W'(1) : seed;
        end else if (step) begin
            state_d = {state_q[CHAL_W-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CHAL_W'(1);
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/cycpuf_crp_driver.sv
// Challenge-side driver for the cyclic-BPUF array.
// Accepts a seed and word count, applies an LFSR challenge sequence to the PUF,
// majority-votes VOTES response samples per challenge after a SETTLE window,
// packs RESP_W voted bits per word (first bit in the MSB) and streams the
// words out over a valid/ready handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of cycpuf_crp_driver_if (seed request / word stream)
//   chal       : registered challenge to the PUF
//   puf_resp   : 1-bit PUF response
//   busy       : high whenever not idle
module cycpuf_crp_driver
    import cycpuf_pkg::*;
#(
    parameter int unsigned       CHAL_W = CYC_CHAL_W,
    parameter logic [CHAL_W-1:0] TAPS   = CYC_TAPS,
    parameter int unsigned       SETTLE = 8,
    parameter int unsigned       VOTES  = 5,
    parameter int unsigned       RESP_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    cycpuf_crp_driver_if.slave  bus,
    output logic [CHAL_W-1:0]   chal,
    input  logic                puf_resp,
    output logic                busy
);

    localparam int unsigned SET_W  = $clog2(SETTLE + 1);
    localparam int unsigned ONES_W = $clog2(VOTES + 1);
    localparam int unsigned BIT_W  = $clog2(RESP_W + 1);
    localparam logic [ONES_W-1:0] THRESH = ONES_W'(maj_threshold(VOTES));

    cyc_state_e          state_q, state_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic [RESP_W-1:0]   shreg_q, shreg_d;
    logic [15:0]         words_left_q, words_left_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [ONES_W-1:0]   vote_cnt_q, vote_cnt_d;
    logic [ONES_W-1:0]   ones_q, ones_d;

    logic                lfsr_load;
    logic                lfsr_step;
    logic [CHAL_W-1:0]   lfsr_state;
    logic [ONES_W-1:0]   ones_sum;
    logic                voted;

    cycpuf_lfsr #(
        .CHAL_W (CHAL_W),
        .TAPS   (TAPS)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (lfsr_load),
        .seed   (bus.seed),
        .step   (lfsr_step),
        .state  (lfsr_state)
    );

    // Current sample is folded in so the vote resolves on the last sample cycle.
    assign ones_sum = ones_q + ONES_W'(puf_resp);
    assign voted    = (ones_sum > THRESH);

    always_comb begin
        state_d      = state_q;
        chal_d       = chal_q;
        shreg_d      = shreg_q;
        words_left_d = words_left_q;
        bit_cnt_d    = bit_cnt_q;
        settle_cnt_d = settle_cnt_q;
        vote_cnt_d   = vote_cnt_q;
        ones_d       = ones_q;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.seed_valid) begin
                    lfsr_load    = 1'b1;
                    words_left_d = bus.num_words;
                    bit_cnt_d    = '0;
                    if (bus.num_words != 16'd0) begin
                        state_d = StApply;
                    end
                end
            end
            StApply: begin
                chal_d       = lfsr_state;
                settle_cnt_d = '0;
                vote_cnt_d   = '0;
                ones_d       = '0;
                state_d      = StSettle;
            end
            StSettle: begin
                if (settle_cnt_q == SET_W'(SETTLE - 1)) begin
                    state_d = StSample;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            StSample: begin
                if (vote_cnt_q == ONES_W'(VOTES - 1)) begin
                    shreg_d   = {shreg_q[RESP_W-2:0], voted};
                    lfsr_step = 1'b1;
                    if (bit_cnt_q == BIT_W'(RESP_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = StEmit;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        state_d   = StApply;
                    end
                end else begin
                    ones_d     = ones_sum;
                    vote_cnt_d = vote_cnt_q + ONES_W'(1);
                end
            end
            StEmit: begin
                if (bus.out_ready) begin
                    words_left_d = words_left_q - 16'd1;
                    state_d      = (words_left_q == 16'd1) ? StIdle : StApply;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            chal_q       <= '0;
            shreg_q      <= '0;
            words_left_q <= '0;
            bit_cnt_q    <= '0;
            settle_cnt_q <= '0;
            vote_cnt_q   <= '0;
            ones_q       <= '0;
        end else begin
            state_q      <= state_d;
            chal_q       <= chal_d;
            shreg_q      <= shreg_d;
            words_left_q <= words_left_d;
            bit_cnt_q    <= bit_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            vote_cnt_q   <= vote_cnt_d;
            ones_q       <= ones_d;
        end
    end

    assign chal           = chal_q;
    assign bus.seed_ready = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign bus.out_valid  = (state_q == StEmit);
    assign bus.out_data   = shreg_q;
    assign bus.out_last   = (state_q == StEmit) && (words_left_q == 16'd1);

endmodule

// File: tb/tb_cycpuf_crp_driver.sv
// Bench for cycpuf_crp_driver with RESP_W=8, SETTLE=2, VOTES=3.
// A PUF model answers chal[0] (optionally forcing chosen vote samples low), a
// word-level model predicts every output word into a queue, and one compare
// process checks handshaked words, stall stability and seed_ready/busy.
module tb_cycpuf_crp_driver;

    localparam int unsigned CHAL_W = 51;
    localparam int unsigned RESP_W = 8;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned VOTES  = 3;
    localparam logic [CHAL_W-1:0] TAPS = 51'h4000000000025;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [CHAL_W-1:0] chal;
    logic              puf_resp = 1'b0;
    logic              busy;

    cycpuf_crp_driver_if #(.CHAL_W(CHAL_W), .RESP_W(RESP_W)) bus ();

    cycpuf_crp_driver #(
        .CHAL_W (CHAL_W),
        .TAPS   (TAPS),
        .SETTLE (SETTLE),
        .VOTES  (VOTES),
        .RESP_W (RESP_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .chal     (chal),
        .puf_resp (puf_resp),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- word-level model ----------------
    // mode 0: every sample = chal[0]; mode 1: samples 2,3 low; mode 2: sample 2 low
    function automatic logic forced(input int mode, input int k);
        return (mode == 1 && (k == 2 || k == 3)) || (mode == 2 && k == 2);
    endfunction

    task automatic model_word(inout logic [CHAL_W-1:0] l, input int mode,
                              output logic [RESP_W-1:0] w);
        w = '0;
        for (int b = 0; b < int'(RESP_W); b++) begin
            int ones = 0;
            for (int k = 1; k <= int'(VOTES); k++) begin
                if (!forced(mode, k)) ones += int'(l[0]);
            end
            w = {w[RESP_W-2:0], (2 * ones > int'(VOTES))};
            l = {l[CHAL_W-2:0], ^(l & TAPS)};
        end
    endtask

    typedef struct packed {
        logic [RESP_W-1:0] data;
        logic              last;
    } exp_t;
    exp_t exp_q[$];

    task automatic expect_run(input logic [CHAL_W-1:0] s, input int n, input int mode);
        logic [CHAL_W-1:0] l;
        logic [RESP_W-1:0] w;
        l = (s == '0) ? CHAL_W'(1) : s;
        for (int i = 0; i < n; i++) begin
            model_word(l, mode, w);
            exp_q.push_back('{data: w, last: (i == n - 1)});
        end
    endtask

    // ---------------- PUF model ----------------
    // Samples are counted from the cycle the new challenge becomes visible.
    int puf_mode = 0;
    int since = 0;
    logic [CHAL_W-1:0] prev_chal = '0;
    always @(negedge clk) begin
        if (chal !== prev_chal) since = 0;
        else since++;
        prev_chal = chal;
        puf_resp = forced(puf_mode, since - int'(SETTLE) + 1) ? 1'b0 : chal[0];
    end

    // ---------------- consumer ----------------
    int bp_en = 0;
    int stall = 0;
    always @(negedge clk) begin
        if (bp_en == 0) begin
            bus.out_ready = 1'b1;
        end else if (bus.out_valid) begin
            if (stall < 20) begin
                bus.out_ready = 1'b0;
                stall++;
            end else begin
                bus.out_ready = 1'b1;
                stall = 0;
            end
        end else begin
            bus.out_ready = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    int words_seen = 0;
    int lasts_seen = 0;
    logic              hold_prev = 1'b0;
    logic [RESP_W-1:0] data_prev;
    logic              last_prev;
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            check("seed_ready_vs_busy", bus.seed_ready, !busy);
            if (hold_prev) begin
                check("stall_valid", bus.out_valid, 1'b1);
                check("stall_data", bus.out_data, data_prev);
                check("stall_last", bus.out_last, last_prev);
            end
            if (bus.out_valid && bus.out_ready) begin
                exp_t e;
                words_seen++;
                if (bus.out_last) lasts_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h, expected no word", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", bus.out_data, e.data);
                    check("word_last", bus.out_last, e.last);
                end
            end
        end
        hold_prev = rst_n && bus.out_valid && !bus.out_ready;
        data_prev = bus.out_data;
        last_prev = bus.out_last;
    end

    // ---------------- stimulus helpers ----------------
    // Offer at a negedge (cycle 0); returns at the negedge of cycle 1.
    task automatic offer(input logic [CHAL_W-1:0] s, input logic [15:0] n);
        @(negedge clk);
        bus.seed       = s;
        bus.num_words  = n;
        bus.seed_valid = 1'b1;
        #2 check("seed_ready_at_offer", bus.seed_ready, 1'b1);
        @(negedge clk);
        bus.seed_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (busy && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("idle_timeout", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("all_words_delivered", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_chal"}, chal, '0);
        check({tag, "_out_data"}, bus.out_data, '0);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_out_last"}, bus.out_last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_seed_ready"}, bus.seed_ready, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CHAL_W-1:0] l;
        logic [RESP_W-1:0] w;
        int lat;
        int w0, l0;

        bus.seed_valid = 1'b0;
        bus.seed       = '0;
        bus.num_words  = '0;

        // Model pins (hand-computed): challenges 1,3,7,14,29,58,117,235 -> EB.
        l = CHAL_W'(1);  model_word(l, 0, w); check("model_seed1", w, 8'hEB);
        check("model_lfsr_after_word", l, 51'd470);
        l = CHAL_W'(1);  model_word(l, 1, w); check("model_force23", w, 8'h00);
        l = CHAL_W'(1);  model_word(l, 2, w); check("model_force2", w, 8'hEB);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2 check_reset_values("reset");

        // Golden word and first-valid latency.
        expect_run(CHAL_W'(1), 1, 0);
        offer(CHAL_W'(1), 16'd1);
        wait_valid(lat);
        check("first_valid_latency", lat, 49);
        check("golden_last", bus.out_last, 1'b1);
        check("golden_data_literal", bus.out_data, 8'hEB);
        wait_idle();

        // Zero seed behaves as seed 1.
        expect_run('0, 1, 0);
        offer('0, 16'd1);
        wait_valid(lat);
        check("zero_seed_literal", bus.out_data, 8'hEB);
        wait_idle();

        // Majority vote.
        puf_mode = 1;
        expect_run(CHAL_W'(1), 1, 1);
        offer(CHAL_W'(1), 16'd1);
        wait_valid(lat);
        check("maj_force23_literal", bus.out_data, 8'h00);
        wait_idle();
        puf_mode = 2;
        expect_run(CHAL_W'(1), 1, 2);
        offer(CHAL_W'(1), 16'd1);
        wait_valid(lat);
        check("maj_force2_literal", bus.out_data, 8'hEB);
        wait_idle();
        puf_mode = 0;

        // Three words unstalled, then stalled; same model expectations.
        expect_run(CHAL_W'(1), 3, 0);
        offer(CHAL_W'(1), 16'd3);
        wait_idle();
        bp_en = 1;
        w0 = words_seen;
        l0 = lasts_seen;
        expect_run(CHAL_W'(1), 3, 0);
        offer(CHAL_W'(1), 16'd3);
        wait_idle();
        check("bp_word_count", words_seen - w0, 3);
        check("bp_last_count", lasts_seen - l0, 1);
        bp_en = 0;

        // num_words = 0: nothing happens.
        w0 = words_seen;
        offer(CHAL_W'(9), 16'd0);
        for (int i = 0; i < 4; i++) begin
            #2 check("zero_count_busy", busy, 1'b0);
            check("zero_count_valid", bus.out_valid, 1'b0);
            @(negedge clk);
        end
        check("zero_count_words", words_seen - w0, 0);

        // seed_valid during SAMPLE is ignored.
        expect_run(CHAL_W'(1), 1, 0);
        offer(CHAL_W'(1), 16'd1);
        repeat (4) @(negedge clk);   // cycle 5: second vote sample
        bus.seed       = CHAL_W'(77);
        bus.num_words  = 16'd5;
        bus.seed_valid = 1'b1;
        #2 check("busy_seed_ready", bus.seed_ready, 1'b0);
        check("busy_busy", busy, 1'b1);
        @(negedge clk);
        bus.seed_valid = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check("ignored_seed_no_restart", busy, 1'b0);

        // Reset during word 2 of 3, then a fresh golden request.
        expect_run(CHAL_W'(1), 3, 0);
        w0 = words_seen;
        offer(CHAL_W'(1), 16'd3);
        for (int i = 0; i < 200 && words_seen == w0; i++) @(negedge clk);
        check("rst_first_word_seen", words_seen - w0, 1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #2 check_reset_values("midrst");
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("midrst_stays_idle", busy, 1'b0);
        expect_run(CHAL_W'(1), 1, 0);
        offer(CHAL_W'(1), 16'd1);
        wait_valid(lat);
        check("midrst_latency", lat, 49);
        check("midrst_golden_literal", bus.out_data, 8'hEB);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
